adder_tree_loader: RTL

- Upstream feeder and result collector for the CSA adder tree.
- Accepts a serial stream of DATA_W-bit samples over a valid/ready handshake and packs DATA_N samples into the tree's packed input vector.
- Holds that vector stable, counts the tree's pipeline latency, then captures the tree's sum into an output register with a valid/ready handshake.
- Provides backpressure so that at most one vector is in flight and no sum is ever lost.

---
 rtl/adder_tree_pkg.sv | 28 ++
 rtl/adder_tree_lat_ctr.sv | 41 ++++
 rtl/adder_tree_loader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/adder_tree_pkg.sv
// Shared types and helpers for the CSA adder tree and its loader.
package adder_tree_pkg;

   // Loader sequencing: no vector in flight, waiting on the tree, holding a sum.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Pipeline depth of a tree built from 3:2 compressor levels: each level
   // turns every group of three rows into two until two rows remain.
   // A tree with two or fewer operands still takes one registered level.
   function automatic int tree_latency(input int n);
      int rows;
      int lv;
      rows = n;
      lv   = 0;
      for (int i = 0; i < 32; i++) begin
         if (rows > 2) begin
            rows = rows - rows / 3;
            lv   = lv + 1;
         end
      end
      return (lv == 0) ? 1 : lv;
   endfunction

endpackage

// File: rtl/adder_tree_lat_ctr.sv
// Loadable down-counter that marks the edge on which the tree's sum is valid.
// Loaded with LATENCY-1 on the launch edge; o_done is high while the count
// is zero, so the capture edge is LATENCY edges after the load.
module adder_tree_lat_ctr #(
   parameter int LATENCY = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_run,
   output logic o_done
);

   localparam int               LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [LAT_W-1:0] LOAD_VAL = LAT_W'(LATENCY - 1);

   logic [LAT_W-1:0] cnt_q;
   logic [LAT_W-1:0] cnt_d;

   // Next count: reload on launch, otherwise count down while running, stop at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         cnt_d = LOAD_VAL;
      end else if (i_run && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_done = (cnt_q == '0);

endmodule

// File: rtl/adder_tree_loader.sv
// Feeder and result collector for the CSA adder tree.
// Packs DATA_N serial samples into the tree's input vector, holds it stable
// while the tree computes, and captures the sum behind a valid/ready port.
// At most one vector is in flight; the next buffer may fill meanwhile.
// Optional build macro ADDER_TREE_LOADER_TLAST_EN: a transfer with i_last
// closes the buffer early and the unused slots are launched as zero.
module adder_tree_loader
   import adder_tree_pkg::*;
#(
   parameter  int DATA_W   = 3,
   parameter  int DATA_N   = 9,
   parameter  int LATENCY  = tree_latency(DATA_N),
   localparam int O_DATA_W = DATA_W + DATA_N,
   localparam int CNT_W    = $clog2(DATA_N + 1)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i_valid,
   output logic                             i_ready,
   input  logic [DATA_W-1:0]                i_sample,
   input  logic                             i_last,
   output logic [0:DATA_N-1][DATA_W-1:0]    o_vec,
   output logic                             o_vec_valid,
   input  logic [O_DATA_W-1:0]              i_sum,
   output logic [O_DATA_W-1:0]              o_sum,
   output logic                             o_sum_valid,
   input  logic                             i_sum_ready
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_N);

   state_t                          state_q, state_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [0:DATA_N-1][DATA_W-1:0]   fill_q, fill_d;
   logic [0:DATA_N-1][DATA_W-1:0]   vec_q, vec_d;
   logic                            vec_vld_q, vec_vld_d;
   logic                            ready_q, ready_d;
   logic [O_DATA_W-1:0]             sum_q, sum_d;
   logic                            sum_vld_q, sum_vld_d;

   logic                            xfer;
   logic                            full;
   logic                            full_nxt;
   logic                            launch;
   logic                            lat_done;

   // i_ready is registered so it is low throughout reset and glitch-free.
   assign xfer   = i_valid && ready_q;
   assign launch = full && (state_q == IDLE);

`ifdef ADDER_TREE_LOADER_TLAST_EN
   logic last_q, last_d;

   // Early-close flag: set by an i_last transfer, cleared when the buffer launches.
   always_comb begin
      last_d = last_q;
      if (launch) begin
         last_d = 1'b0;
      end else if (xfer && i_last) begin
         last_d = 1'b1;
      end
   end

   // Early-close flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b0;
      end else begin
         last_q <= last_d;
      end
   end

   assign full     = (cnt_q == FULL_CNT) || last_q;
   assign full_nxt = (cnt_d == FULL_CNT) || last_d;
`else
   logic unused_last;
   assign unused_last = i_last;

   assign full     = (cnt_q == FULL_CNT);
   assign full_nxt = (cnt_d == FULL_CNT);
`endif

   assign ready_d = !full_nxt;

   // Fill side: write each accepted sample into the next free slot; a launch empties the buffer.
   always_comb begin
      cnt_d  = cnt_q;
      fill_d = fill_q;
      if (launch) begin
         cnt_d = '0;
      end else if (xfer) begin
         for (int k = 0; k < DATA_N; k++) begin
            if (cnt_q == CNT_W'(k)) begin
               fill_d[k] = i_sample;
            end
         end
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Tree input vector: copy the buffer on launch and hold it until the next launch.
   always_comb begin
      vec_d = vec_q;
      if (launch) begin
         vec_d = fill_q;
`ifdef ADDER_TREE_LOADER_TLAST_EN
         // Slots past the early-closed fill point may hold stale samples.
         for (int k = 0; k < DATA_N; k++) begin
            if (CNT_W'(k) >= cnt_q) begin
               vec_d[k] = '0;
            end
         end
`endif
      end
   end

   // Sequencing: launch from IDLE, capture the tree sum when the latency expires, release on handshake.
   always_comb begin
      state_d   = state_q;
      sum_d     = sum_q;
      sum_vld_d = sum_vld_q;
      vec_vld_d = launch;
      case (state_q)
         IDLE: begin
            if (launch) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (lat_done) begin
               sum_d     = i_sum;
               sum_vld_d = 1'b1;
               state_d   = HOLD;
            end
         end
         HOLD: begin
            if (i_sum_ready && sum_vld_q) begin
               sum_vld_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            sum_vld_d = 1'b0;
         end
      endcase
   end

   // State, buffer and output registers; reset discards everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         fill_q    <= '0;
         vec_q     <= '0;
         vec_vld_q <= 1'b0;
         ready_q   <= 1'b0;
         sum_q     <= '0;
         sum_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         fill_q    <= fill_d;
         vec_q     <= vec_d;
         vec_vld_q <= vec_vld_d;
         ready_q   <= ready_d;
         sum_q     <= sum_d;
         sum_vld_q <= sum_vld_d;
      end
   end

   adder_tree_lat_ctr #(
      .LATENCY (LATENCY)
   ) u_lat_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (launch),
      .i_run   (state_q == WAIT),
      .o_done  (lat_done)
   );

   assign i_ready     = ready_q;
   assign o_vec       = vec_q;
   assign o_vec_valid = vec_vld_q;
   assign o_sum       = sum_q;
   assign o_sum_valid = sum_vld_q;

endmodule
